// File: rtl/fib_seq_gen.sv
// Iterative Fibonacci-style term generator with optional custom seeds.
// Term n is produced n+1 clocks after start, with a sticky truncation flag.
module fib_seq_gen #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0]  seed_a,
    input  logic [DATA_WIDTH-1:0]  seed_b,
    input  logic                   use_seeds,
    input  logic                   start,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   done,
    output logic                   busy,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  r0;
    logic [DATA_WIDTH-1:0]  r1;
    logic [INDEX_WIDTH-1:0] cnt;
    logic                   ov0;
    logic                   ov1;
    logic [DATA_WIDTH:0]    sum;

    assign sum  = {1'b0, r0} + {1'b0, r1};
    assign busy = (state == CALC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            r0       <= '0;
            r1       <= '0;
            cnt      <= '0;
            ov0      <= 1'b0;
            ov1      <= 1'b0;
            dout     <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        r0    <= use_seeds ? seed_a : '0;
                        r1    <= use_seeds ? seed_b : DATA_WIDTH'(1);
                        cnt   <= din;
                        ov0   <= 1'b0;
                        ov1   <= 1'b0;
                        done  <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        // ov tags follow their terms; a carry marks the new term
                        r0  <= r1;
                        r1  <= sum[DATA_WIDTH-1:0];
                        ov0 <= ov1;
                        ov1 <= ov0 | ov1 | sum[DATA_WIDTH];
                        cnt <= cnt - 1'b1;
                    end else begin
                        dout     <= r0;
                        overflow <= ov0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Randomized self-checking bench for fib_seq_gen against an exact
// saturating-arithmetic reference of the term sequence.
module tb_fib_seq_gen;

    localparam int DW = 16;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [IW-1:0] din = '0;
    logic [DW-1:0] seed_a = '0;
    logic [DW-1:0] seed_b = '0;
    logic          use_seeds = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dout;
    logic          done;
    logic          busy;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    fib_seq_gen #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .seed_a(seed_a),
        .seed_b(seed_b),
        .use_seeds(use_seeds),
        .start(start),
        .dout(dout),
        .done(done),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Exact terms clamped at 2^DW (clamping commutes with addition of
    // non-negative values), plus the wrapped terms kept separately.
    function automatic void model(input int n, input bit use_s,
                                  input logic [DW-1:0] a,
                                  input logic [DW-1:0] b,
                                  output logic [DW-1:0] val,
                                  output bit ov);
        longint cap = longint'(1) << DW;
        longint t0 = use_s ? longint'(a) : 0;
        longint t1 = use_s ? longint'(b) : 1;
        longint tn;
        longint m0 = t0;
        longint m1 = t1;
        longint mn;
        for (int i = 0; i < n; i++) begin
            tn = t0 + t1;
            if (tn > cap) tn = cap;
            mn = (m0 + m1) % cap;
            t0 = t1;
            t1 = tn;
            m0 = m1;
            m1 = mn;
        end
        val = DW'(m0);
        ov  = (t0 >= cap);
    endfunction

    task automatic issue(input int n, input bit use_s,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input string tag);
        @(negedge clk);
        din       = IW'(n);
        use_seeds = use_s;
        seed_a    = a;
        seed_b    = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        din       = IW'($urandom);
        seed_a    = DW'($urandom);
        seed_b    = DW'($urandom);
        use_seeds = 1'($urandom);
        check({tag, "_busy_acc"}, 32'(busy), 32'd1);
        check({tag, "_done_acc"}, 32'(done), 32'd0);
    endtask

    task automatic wait_done(input int pre, input int n,
                             input logic [DW-1:0] exp, input bit exp_ov,
                             input string tag);
        int lat = pre;
        while (!done && lat < n + 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(n + 1));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        check({tag, "_ov"}, 32'(overflow), 32'(exp_ov));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run(input int n, input bit use_s,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input string tag);
        logic [DW-1:0] ev;
        bit            eo;
        model(n, use_s, a, b, ev, eo);
        issue(n, use_s, a, b, tag);
        wait_done(0, n, ev, eo, tag);
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;

        reset = 1'b1;
        #12;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ov", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n <= 24; n++)
            run(n, 1'b0, '0, '0, $sformatf("fib%0d", n));

        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 32'(done), 32'd1);
        check("hold_dout", 32'(dout), 32'd46368);

        issue(25, 1'b0, '0, '0, "fib25");
        wait_done(0, 25, 16'd9489, 1'b1, "fib25");
        issue(26, 1'b0, '0, '0, "fib26");
        wait_done(0, 26, 16'd55857, 1'b1, "fib26");

        issue(10, 1'b1, 16'd2, 16'd1, "lucas10");
        wait_done(0, 10, 16'd123, 1'b0, "lucas10");

        issue(20, 1'b0, '0, '0, "ign");
        @(negedge clk);
        din   = IW'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        wait_done(1, 20, 16'd6765, 1'b0, "ign");

        issue(20, 1'b0, '0, '0, "rst");
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_dout", 32'(dout), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ov", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_post_done", 32'(done), 32'd0);
        check("rst_post_dout", 32'(dout), 32'd0);
        issue(7, 1'b0, '0, '0, "fib7");
        wait_done(0, 7, 16'd13, 1'b0, "fib7");

        issue(5, 1'b0, '0, '0, "b2b");
        wait_done(0, 5, 16'd5, 1'b0, "b2b");

        ra = DW'($urandom);
        rb = DW'($urandom);
        run(0, 1'b1, ra, rb, "seed_n0");
        run(1, 1'b1, ra, rb, "seed_n1");

        for (int i = 0; i < 40; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            run(int'($urandom_range(0, 60)), 1'($urandom), ra, rb,
                $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fib_seq_gen.md
FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bit width of seeds, terms and dout.
REQ-002 SHALL have parameter INDEX_WIDTH, default 16, bit width of din (term index n).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port din  input  INDEX_WIDTH  requested term index n, unsigned.
REQ-006 SHALL have port seed_a  input  DATA_WIDTH  term 0 when use_seeds=1.
REQ-007 SHALL have port seed_b  input  DATA_WIDTH  term 1 when use_seeds=1.
REQ-008 SHALL have port use_seeds  input  1  0 = Fibonacci seeds (0,1); 1 = seeds (seed_a, seed_b).
REQ-009 SHALL have port start  input  1  single-cycle request pulse.
REQ-010 SHALL have port dout  output  DATA_WIDTH  term n, modulo 2^DATA_WIDTH.
REQ-011 SHALL have port done  output  1  result valid.
REQ-012 SHALL have port busy  output  1  computation in progress.
REQ-013 SHALL have port overflow  output  1  dout is truncated (true term >= 2^DATA_WIDTH).

Function
REQ-014 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-015 In IDLE or DONE, start=1 at a clock edge SHALL load r0/r1 with the selected seeds, load cnt with din, clear the per-register overflow tags ov0/ov1, clear done, and enter CALC.
REQ-016 In CALC with cnt!=0, each edge SHALL perform r0<=r1, r1<=r0+r1 (truncated to DATA_WIDTH), ov0<=ov1, ov1<=ov0|ov1|carry, cnt<=cnt-1.
REQ-017 In CALC with cnt==0, the edge SHALL register dout<=r0 and overflow<=ov0, set done=1, and enter DONE.
REQ-018 Latency: for index n, done SHALL rise exactly n+1 clock edges after the edge that samples start; for n=0 this is the next edge.
REQ-019 In DONE, done, dout and overflow SHALL hold until the next accepted start or reset.
REQ-020 start while in CALC SHALL be ignored, with no effect on registers or outputs.
REQ-021 Inputs din, seed_a, seed_b and use_seeds SHALL be sampled only at the accepting edge; later changes SHALL have no effect.
REQ-022 busy SHALL be 1 exactly when the state is CALC.
REQ-023 Arithmetic SHALL be unsigned and wrap modulo 2^DATA_WIDTH.
REQ-024 overflow SHALL be sticky per term, so that any truncated ancestor of the term marks it.
REQ-025 Overflow on terms computed beyond n SHALL NOT affect the result.
REQ-026 The maximum index SHALL be 2^INDEX_WIDTH-1 with no early termination.
REQ-027 For use_seeds=1 with n=0, dout SHALL be seed_a with overflow=0.
REQ-028 For use_seeds=1 with n=1, dout SHALL be seed_b with overflow=0.

Reset
REQ-029 Asserting reset SHALL immediately force state to IDLE and dout, done, busy, overflow, r0, r1, cnt, ov0 and ov1 to 0, including mid-CALC or in DONE.
REQ-030 After reset deasserts, the first start SHALL be accepted normally, and no stale result SHALL reappear.

Verification (DATA_WIDTH=16, INDEX_WIDTH=16)
REQ-031 Sweep n=0..24 with use_seeds=0 -> dout=fib(n) (e.g. n=0 -> 0, n=24 -> 46368), overflow=0, done exactly n+1 cycles after start.
REQ-032 n=25 and use_seeds=0 -> dout=9489 (75025 mod 65536), overflow=1; n=26 -> dout=55857 (121393 mod 65536), overflow=1.
REQ-033 use_seeds=1 with seed_a=2, seed_b=1 (Lucas), n=10 -> dout=123, overflow=0, done after 11 cycles.
REQ-034 Issue start with n=20; pulse start again with n=3 while busy=1 -> second start is ignored, result is 6765.
REQ-035 Issue start with n=20; assert reset 5 cycles later -> all outputs 0 immediately; then start with n=7 -> dout=13, done after 8 cycles.
REQ-036 From DONE, issue back-to-back start with n=5 -> done drops on the next edge, busy=1, then dout=5 with done high.
